// File: rtl/pio_pkg.sv
// Shared definitions for the edge-interrupt input PIO.
// Holds the word-address map and a helper that zero-extends a channel vector
// to the 32-bit Avalon data width.
package pio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] PIO_DATA = 3'd0;
    localparam logic [ADDR_W-1:0] PIO_RISE = 3'd1;
    localparam logic [ADDR_W-1:0] PIO_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] PIO_CAP  = 3'd3;
    localparam logic [ADDR_W-1:0] PIO_FALL = 3'd4;
    localparam logic [ADDR_W-1:0] PIO_DBP  = 3'd5;

    // The caller casts its WIDTH-bit vector to 32 bits first.
    // Bits at or above w are forced to zero.
    function automatic logic [BUS_W-1:0] pio_zext(input logic [BUS_W-1:0] v,
                                                  input int unsigned w);
        logic [63:0] keep;
        keep = (64'd1 << w) - 64'd1;
        return v & keep[BUS_W-1:0];
    endfunction

endpackage

// File: rtl/pio_in_conditioner.sv
// Input conditioning for the edge-interrupt PIO.
// Each input goes through a synchroniser and then a tick-sampled debouncer.
// A single prescaler is shared by all channels.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   in_port       asynchronous external inputs
//   db_period     debounce tick period in clk; 0 bypasses the debouncer
//   db_restart    pulse: restart the prescaler at 0 (period register written)
//   deb           debounced, registered channel values
module pio_in_conditioner
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DBW         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [DBW-1:0]   db_period,
    input  logic             db_restart,
    output logic [WIDTH-1:0] deb
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [DBW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] deb_q, deb_d;

    logic [WIDTH-1:0] sync_c;
    logic             bypass_c;
    logic             tick_c;
    logic [WIDTH-1:0] agree_c;

    // Synchroniser shift chain
    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_c   = sync_q[SYNC_STAGES-1];
    assign bypass_c = (db_period == '0);
    assign tick_c   = !bypass_c && (count_q == (db_period - DBW'(1)));

    // Prescaler and debounce next state
    always_comb begin
        count_d = count_q + DBW'(1);
        if (db_restart || bypass_c || tick_c) begin
            count_d = '0;
        end

        samp_d  = tick_c ? sync_c : samp_q;
        // A bit follows sync only when two consecutive tick samples agree.
        agree_c = tick_c ? ~(sync_c ^ samp_q) : '0;
        deb_d   = (deb_q & ~agree_c) | (sync_c & agree_c);
        if (bypass_c) begin
            deb_d = sync_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            count_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
        end else begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            count_q <= count_d;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO with per-bit edge capture and a level interrupt.
// Ports:
//   clk, reset_n            clock and async active-low reset
//   address, chipselect,    Avalon-MM slave, no wait states,
//   write_n, writedata      write strobe = chipselect && !write_n
//   in_port                 asynchronous external inputs
//   readdata                registered read data, 1 cycle latency
//   irq                     registered level interrupt, active high
module pio_edge_irq_in
    import pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     DBW         = 16,
    parameter int unsigned     DB_RST      = 0,
    parameter logic [WIDTH-1:0] RISE_RST   = '1,
    parameter logic [WIDTH-1:0] FALL_RST   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [BUS_W-1:0]  readdata,
    output logic              irq
);

    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [DBW-1:0]   dbp_q, dbp_d;
    logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [BUS_W-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] deb_c;
    logic [WIDTH-1:0] ev_c;
    logic [WIDTH-1:0] clr_c;
    logic             unused_wdata;

    assign wr_c    = chipselect && !write_n;
    assign wdata_c = writedata[WIDTH-1:0];
    // Upper write-data bits have no home when WIDTH < 32.
    assign unused_wdata = ^writedata;

    pio_in_conditioner #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .DBW        (DBW)
    ) u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .db_period (dbp_q),
        .db_restart(wr_c && (address == PIO_DBP)),
        .deb       (deb_c)
    );

    // Edges come only from debounced transitions, never from enable writes.
    assign ev_c  = (rise_q & deb_c & ~deb_prev_q) | (fall_q & ~deb_c & deb_prev_q);
    assign clr_c = (wr_c && (address == PIO_CAP)) ? wdata_c : '0;

    // Register file, capture, irq and read-data next state
    always_comb begin
        rise_d     = rise_q;
        fall_d     = fall_q;
        mask_d     = mask_q;
        dbp_d      = dbp_q;
        deb_prev_d = deb_c;
        // A new edge beats a simultaneous write-1-to-clear.
        cap_d      = ev_c | (cap_q & ~clr_c);
        irq_d      = |(cap_q & mask_q);

        if (wr_c) begin
            unique case (address)
                PIO_RISE: rise_d = wdata_c;
                PIO_MASK: mask_d = wdata_c;
                PIO_FALL: fall_d = wdata_c;
                PIO_DBP:  dbp_d  = writedata[DBW-1:0];
                default:  ;
            endcase
        end

        unique case (address)
            PIO_DATA: readdata_d = pio_zext(BUS_W'(deb_c), WIDTH);
            PIO_RISE: readdata_d = pio_zext(BUS_W'(rise_q), WIDTH);
            PIO_MASK: readdata_d = pio_zext(BUS_W'(mask_q), WIDTH);
            PIO_CAP:  readdata_d = pio_zext(BUS_W'(cap_q), WIDTH);
            PIO_FALL: readdata_d = pio_zext(BUS_W'(fall_q), WIDTH);
            PIO_DBP:  readdata_d = BUS_W'(dbp_q);
            default:  readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q     <= RISE_RST;
            fall_q     <= FALL_RST;
            mask_q     <= '0;
            cap_q      <= '0;
            dbp_q      <= DBW'(DB_RST);
            deb_prev_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            dbp_q      <= dbp_d;
            deb_prev_q <= deb_prev_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Directed bench for pio_edge_irq_in (WIDTH=8, SYNC_STAGES=2, DBW=16, bypass at reset).
module tb_pio_edge_irq_in;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int vectors;
    int miscompares;
    logic [31:0] rd_val;

    pio_edge_irq_in #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .DBW        (16),
        .DB_RST     (0),
        .RISE_RST   (8'hFF),
        .FALL_RST   (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        address = 3'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'd0;
        in_port = 8'h00;
        wait_clk(3);
        reset_n = 1'b1;

        // Reset defaults
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        bus_rd(3'd1, rd_val); chk("rst_rise", rd_val, 32'h0000_00FF);
        bus_rd(3'd2, rd_val); chk("rst_mask", rd_val, 32'h0);
        bus_rd(3'd3, rd_val); chk("rst_cap", rd_val, 32'h0);
        bus_rd(3'd4, rd_val); chk("rst_fall", rd_val, 32'h0);
        bus_rd(3'd5, rd_val); chk("rst_dbp", rd_val, 32'h0);

        // Rising capture in bypass: irq exactly SYNC_STAGES+3 = 5 clk after input
        bus_wr(3'd2, 32'h01);
        in_port = 8'h01;
        wait_clk(4);
        chk("rise_irq_early", 32'(irq), 32'd0);
        wait_clk(1);
        chk("rise_irq_at5", 32'(irq), 32'd1);
        bus_rd(3'd3, rd_val); chk("rise_cap", rd_val, 32'h01);
        bus_rd(3'd0, rd_val); chk("rise_data", rd_val, 32'h01);
        bus_wr(3'd3, 32'h01);
        chk("w1c_irq_hold", 32'(irq), 32'd1);
        wait_clk(1);
        chk("w1c_irq_low", 32'(irq), 32'd0);
        bus_rd(3'd3, rd_val); chk("w1c_cap", rd_val, 32'h00);

        // Falling-only on bit1
        bus_wr(3'd1, 32'h00);
        bus_wr(3'd4, 32'h02);
        in_port = 8'h03;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("fall_no_rise", rd_val, 32'h00);
        in_port = 8'h01;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("fall_cap", rd_val, 32'h02);
        bus_wr(3'd3, 32'hFF);
        // Any-edge on bit1
        bus_wr(3'd1, 32'h02);
        in_port = 8'h03;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("any_rise", rd_val, 32'h02);
        bus_wr(3'd3, 32'h02);
        in_port = 8'h01;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("any_fall", rd_val, 32'h02);
        bus_wr(3'd3, 32'h02);
        // Bit0 has neither enable
        in_port = 8'h00;
        wait_clk(6);
        in_port = 8'h01;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("bit0_disabled", rd_val, 32'h00);
        chk("bit0_irq", 32'(irq), 32'd0);

        // Debounce with period 4
        bus_wr(3'd1, 32'h04);
        bus_wr(3'd4, 32'h00);
        bus_wr(3'd5, 32'h04);
        bus_rd(3'd5, rd_val); chk("dbp_rd", rd_val, 32'h04);
        wait_clk(10);
        in_port = 8'h05;
        wait_clk(3);
        in_port = 8'h01;
        wait_clk(20);
        bus_rd(3'd0, rd_val); chk("glitch_data", rd_val, 32'h01);
        bus_rd(3'd3, rd_val); chk("glitch_cap", rd_val, 32'h00);
        in_port = 8'h05;
        wait_clk(10);
        bus_rd(3'd0, rd_val); chk("deb_data", rd_val, 32'h05);
        wait_clk(10);
        bus_rd(3'd3, rd_val); chk("deb_cap", rd_val, 32'h04);
        bus_wr(3'd3, 32'h04);
        wait_clk(10);
        bus_rd(3'd3, rd_val); chk("deb_single", rd_val, 32'h00);
        bus_wr(3'd5, 32'h00);

        // Simultaneous set and clear
        bus_wr(3'd1, 32'hFF);
        in_port = 8'h04;
        wait_clk(6);
        in_port = 8'h07;
        wait_clk(6);
        in_port = 8'h06;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("pre_sim_cap", rd_val, 32'h03);
        in_port = 8'h07;
        wait_clk(3);
        address    = 3'd3;
        writedata  = 32'h03;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_rd(3'd3, rd_val); chk("sim_set_wins", rd_val, 32'h01);
        // W1C selectivity
        in_port = 8'h05;
        wait_clk(6);
        in_port = 8'h07;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("sel_pre", rd_val, 32'h03);
        bus_wr(3'd3, 32'h02);
        bus_rd(3'd3, rd_val); chk("sel_w1c", rd_val, 32'h01);

        // Masking
        bus_wr(3'd3, 32'hFF);
        bus_wr(3'd2, 32'h00);
        in_port = 8'h06;
        wait_clk(6);
        in_port = 8'h07;
        wait_clk(6);
        bus_rd(3'd3, rd_val); chk("masked_cap", rd_val, 32'h01);
        chk("masked_irq", 32'(irq), 32'd0);
        bus_wr(3'd2, 32'h01);
        chk("unmask_irq_lag", 32'(irq), 32'd0);
        wait_clk(1);
        chk("unmask_irq", 32'(irq), 32'd1);

        // Unmapped address
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, rd_val); chk("unmap_rd6", rd_val, 32'h0);
        bus_rd(3'd7, rd_val); chk("unmap_rd7", rd_val, 32'h0);
        bus_rd(3'd1, rd_val); chk("unmap_rise", rd_val, 32'hFF);
        bus_rd(3'd2, rd_val); chk("unmap_mask", rd_val, 32'h01);
        bus_rd(3'd3, rd_val); chk("unmap_cap", rd_val, 32'h01);
        bus_rd(3'd4, rd_val); chk("unmap_fall", rd_val, 32'h00);
        bus_rd(3'd5, rd_val); chk("unmap_dbp", rd_val, 32'h00);

        // Reset mid-count
        bus_wr(3'd5, 32'h04);
        wait_clk(2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_rd", readdata, 32'd0);
        wait_clk(2);
        reset_n = 1'b1;
        bus_rd(3'd1, rd_val); chk("post_rise", rd_val, 32'hFF);
        bus_rd(3'd2, rd_val); chk("post_mask", rd_val, 32'h00);
        bus_rd(3'd4, rd_val); chk("post_fall", rd_val, 32'h00);
        bus_rd(3'd5, rd_val); chk("post_dbp", rd_val, 32'h00);
        wait_clk(4);
        bus_rd(3'd0, rd_val); chk("post_data", rd_val, 32'h07);
        bus_rd(3'd3, rd_val); chk("post_cap", rd_val, 32'h07);
        chk("post_irq", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
